// File: rtl/color_blob_tracker.sv
// Multi-target colour-blob tracker: per-target pixel classification, frame
// accumulation of count and coordinate sums, and sequential centroid division.
module color_blob_tracker #(
  parameter int NUM_TARGETS = 2,
  parameter int H_WIDTH     = 11,
  parameter int V_WIDTH     = 10,
  parameter int TOL         = 1,
  parameter int MIN_PIXELS  = 16,
  parameter int CNT_W       = H_WIDTH + V_WIDTH,
  parameter int SUM_W       = CNT_W + H_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pixel_valid,
  input  logic [11:0]                  cam,
  input  logic [H_WIDTH-1:0]           hcount,
  input  logic [V_WIDTH-1:0]           vcount,
  input  logic                         frame_start,
  input  logic                         frame_end,
  input  logic [12*NUM_TARGETS-1:0]    target_color,
  output logic [NUM_TARGETS-1:0]       thres_mask,
  output logic [H_WIDTH*NUM_TARGETS-1:0] x_center,
  output logic [V_WIDTH*NUM_TARGETS-1:0] y_center,
  output logic [CNT_W*NUM_TARGETS-1:0] pix_count,
  output logic [NUM_TARGETS-1:0]       found,
  output logic                         result_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CH_W   = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int STEP_W = $clog2(SUM_W + 1);
  localparam logic [CH_W:0] LAST_Q = (CH_W+1)'(2*NUM_TARGETS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE} state_t;
  state_t state;

  logic [CNT_W-1:0]   cnt [NUM_TARGETS];
  logic [SUM_W-1:0]   sx  [NUM_TARGETS];
  logic [SUM_W-1:0]   sy  [NUM_TARGETS];
  logic [H_WIDTH-1:0] xq  [NUM_TARGETS];
  logic [V_WIDTH-1:0] yq  [NUM_TARGETS];

  logic [NUM_TARGETS-1:0] match_now;
  logic [CH_W:0]          q_idx;
  logic [STEP_W-1:0]      step;
  logic [SUM_W-1:0]       rem, quo, dividend, rem_next, quo_next;
  logic [CNT_W-1:0]       divisor;
  logic [SUM_W:0]         shifted;
  logic                   div_ge, ch_found;
  logic [CH_W-1:0]        ch;
  logic                   axis;

  // Quotient order is x0, y0, x1, y1, ...: low bit picks the axis.
  assign ch   = q_idx[CH_W:1];
  assign axis = q_idx[0];

  function automatic logic near(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] d;
    d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return d <= 5'(TOL);
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
      match_now[k] = near(cam[11:8], target_color[12*k+8 +: 4]) &&
                     near(cam[7:4],  target_color[12*k+4 +: 4]) &&
                     near(cam[3:0],  target_color[12*k   +: 4]);
    end
  end

  always_comb begin
    dividend = '0;
    divisor  = '0;
    for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
      if (ch == CH_W'(k)) begin
        dividend = axis ? sy[k] : sx[k];
        divisor  = cnt[k];
      end
    end
    ch_found = divisor >= CNT_W'(MIN_PIXELS);
    shifted  = {rem, quo[SUM_W-1]};
    div_ge   = shifted >= (SUM_W+1)'(divisor);
    rem_next = div_ge ? SUM_W'(shifted - (SUM_W+1)'(divisor)) : shifted[SUM_W-1:0];
    quo_next = {quo[SUM_W-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      q_idx        <= '0;
      step         <= '0;
      rem          <= '0;
      quo          <= '0;
      thres_mask   <= '0;
      x_center     <= '0;
      y_center     <= '0;
      pix_count    <= '0;
      found        <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
        cnt[k] <= '0;
        sx[k]  <= '0;
        sy[k]  <= '0;
        xq[k]  <= '0;
        yq[k]  <= '0;
      end
    end else begin
      thres_mask   <= {NUM_TARGETS{pixel_valid}} & match_now;
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
              cnt[k] <= '0;
              sx[k]  <= '0;
              sy[k]  <= '0;
            end
            state <= ACCUM;
          end
        end
        ACCUM: begin
          // Accumulators stay frozen through DIVIDE and serve as the snapshot.
          if (frame_end) begin
            state <= DIVIDE;
            busy  <= 1'b1;
            q_idx <= '0;
            step  <= '0;
            if (frame_start) overrun <= 1'b1;
          end else if (frame_start) begin
            for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
              cnt[k] <= '0;
              sx[k]  <= '0;
              sy[k]  <= '0;
            end
          end else if (pixel_valid) begin
            for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
              if (match_now[k] && (cnt[k] != '1)) begin
                cnt[k] <= cnt[k] + CNT_W'(1);
                sx[k]  <= sx[k] + SUM_W'(hcount);
                sy[k]  <= sy[k] + SUM_W'(vcount);
              end
            end
          end
        end
        DIVIDE: begin
          if (frame_start) overrun <= 1'b1;
          if (result_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (step == '0) begin
            rem  <= '0;
            quo  <= ch_found ? dividend : '0;
            step <= STEP_W'(1);
          end else begin
            if (ch_found) begin
              rem <= rem_next;
              quo <= quo_next;
            end
            if (step == STEP_W'(SUM_W)) begin
              step  <= '0;
              q_idx <= q_idx + (CH_W+1)'(1);
              for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
                if (ch_found && (ch == CH_W'(k))) begin
                  if (axis) yq[k] <= quo_next[V_WIDTH-1:0];
                  else      xq[k] <= quo_next[H_WIDTH-1:0];
                end
              end
              // Final quotient is forwarded straight from the divider output.
              if (q_idx == LAST_Q) begin
                result_valid <= 1'b1;
                for (int unsigned k = 0; k < NUM_TARGETS; k++) begin
                  found[k] <= cnt[k] >= CNT_W'(MIN_PIXELS);
                  pix_count[k*CNT_W +: CNT_W] <= cnt[k];
                  if (cnt[k] >= CNT_W'(MIN_PIXELS)) begin
                    x_center[k*H_WIDTH +: H_WIDTH] <= xq[k];
                    y_center[k*V_WIDTH +: V_WIDTH] <=
                      (k == unsigned'(NUM_TARGETS - 1)) ? quo_next[V_WIDTH-1:0] : yq[k];
                  end
                end
              end
            end else begin
              step <= step + STEP_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Scoreboard bench for color_blob_tracker: frame-level reference model feeds
// expected results into a queue checked by an independent output monitor.
module tb_color_blob_tracker;
  localparam int NT = 2, HW = 11, VW = 10, TOL = 1, MINP = 16, CW = HW + VW;

  logic clk = 1'b0;
  logic reset, pixel_valid, frame_start, frame_end;
  logic [11:0] cam, tc0, tc1;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [12*NT-1:0] target_color;
  logic [NT-1:0] thres_mask, found;
  logic [HW*NT-1:0] x_center;
  logic [VW*NT-1:0] y_center;
  logic [CW*NT-1:0] pix_count;
  logic result_valid, busy, overrun;

  assign target_color = {tc1, tc0};
  always #5 clk = ~clk;

  color_blob_tracker #(.NUM_TARGETS(NT), .H_WIDTH(HW), .V_WIDTH(VW), .TOL(TOL),
                       .MIN_PIXELS(MINP)) dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .cam(cam),
    .hcount(hcount), .vcount(vcount), .frame_start(frame_start),
    .frame_end(frame_end), .target_color(target_color), .thres_mask(thres_mask),
    .x_center(x_center), .y_center(y_center), .pix_count(pix_count),
    .found(found), .result_valid(result_valid), .busy(busy), .overrun(overrun));

  typedef struct {
    logic [NT-1:0][63:0] cnt;
    logic [NT-1:0][63:0] sx;
    logic [NT-1:0][63:0] sy;
    longint rv_cyc;
  } exp_t;

  exp_t sb[$];
  int fc[$], fh[$], fv[$], fpv[$];
  int unsigned n_vec = 0, n_err = 0;
  longint cyc = 0, busy_lo = 1, busy_hi = 0;
  bit exp_ovr = 0, m_accum = 0;
  longint exp_pc[NT], exp_x[NT], exp_y[NT], exp_fnd[NT];
  logic [NT-1:0] m_exp;
  exp_t e;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit match_px(int c, int t);
    for (int s = 0; s <= 8; s += 4) begin
      int a = (c >> s) & 15;
      int b = (t >> s) & 15;
      if (((a > b) ? a - b : b - a) > TOL) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitor: compares every cycle, pops the scoreboard on result_valid.
  always @(posedge clk) begin
    cyc++;
    m_exp = '0;
    if (!reset && pixel_valid)
      for (int k = 0; k < NT; k++) m_exp[k] = match_px(int'(cam), int'(target_color[12*k +: 12]));
    #1;
    chk("thres_mask", thres_mask, m_exp);
    chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    chk("overrun", overrun, exp_ovr);
    if (result_valid) begin
      if (sb.size() == 0) chk("result_valid_unexpected", result_valid, 0);
      else begin
        e = sb.pop_front();
        chk("result_latency", cyc, e.rv_cyc);
        for (int k = 0; k < NT; k++) begin
          exp_pc[k]  = longint'(e.cnt[k]);
          exp_fnd[k] = (e.cnt[k] >= MINP) ? 1 : 0;
          if (exp_fnd[k] == 1) begin
            exp_x[k] = longint'(e.sx[k] / e.cnt[k]) % (1 << HW);
            exp_y[k] = longint'(e.sy[k] / e.cnt[k]) % (1 << VW);
          end
        end
      end
    end else if (sb.size() > 0 && sb[0].rv_cyc < cyc) begin
      chk("result_valid_missing", result_valid, 1);
      void'(sb.pop_front());
    end
    for (int k = 0; k < NT; k++) begin
      chk($sformatf("pix_count%0d", k), pix_count[k*CW +: CW], exp_pc[k]);
      chk($sformatf("found%0d", k), found[k], exp_fnd[k]);
      chk($sformatf("x_center%0d", k), x_center[k*HW +: HW], exp_x[k]);
      chk($sformatf("y_center%0d", k), y_center[k*VW +: VW], exp_y[k]);
    end
  end

  task automatic clr_frame();
    fc.delete(); fh.delete(); fv.delete(); fpv.delete();
  endtask

  task automatic add_px(int c, int h, int v, int pv);
    fc.push_back(c); fh.push_back(h); fv.push_back(v); fpv.push_back(pv);
  endtask

  task automatic build_test1();
    clr_frame();
    for (int v = 48; v <= 55; v++)
      for (int h = 98; h <= 105; h++)
        add_px((h >= 100 && h <= 103 && v >= 50 && v <= 53) ? 'hF00 : 0, h, v, 1);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    busy_lo = 1; busy_hi = 0; exp_ovr = 0; m_accum = 0;
    for (int k = 0; k < NT; k++) begin
      exp_pc[k] = 0; exp_x[k] = 0; exp_y[k] = 0; exp_fnd[k] = 0;
    end
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_frame();
    exp_t x;
    int t;
    @(negedge clk);
    frame_start = 1'b1;
    if (cyc >= busy_lo && cyc <= busy_hi) exp_ovr = 1;
    else m_accum = 1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < fc.size(); i++) begin
      pixel_valid = fpv[i][0];
      cam = 12'(fc[i]);
      hcount = HW'(fh[i]);
      vcount = VW'(fv[i]);
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    cam = '0;
    frame_end = 1'b1;
    if (m_accum) begin
      for (int k = 0; k < NT; k++) begin
        t = (k == 0) ? int'(tc0) : int'(tc1);
        x.cnt[k] = 0; x.sx[k] = 0; x.sy[k] = 0;
        for (int i = 0; i < fc.size(); i++)
          if (fpv[i] != 0 && match_px(fc[i], t)) begin
            x.cnt[k] += 1; x.sx[k] += 64'(fh[i]); x.sy[k] += 64'(fv[i]);
          end
      end
      x.rv_cyc = cyc + 133;
      sb.push_back(x);
      busy_lo = cyc + 1;
      busy_hi = cyc + 133;
      m_accum = 0;
    end
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc <= busy_hi + 1) @(negedge clk);
  endtask

  task automatic chk_t(string tag, int k, int pc, int xc, int yc, int f);
    chk({tag, "_pix_count"}, pix_count[k*CW +: CW], pc);
    chk({tag, "_x_center"}, x_center[k*HW +: HW], xc);
    chk({tag, "_y_center"}, y_center[k*VW +: VW], yc);
    chk({tag, "_found"}, found[k], f);
  endtask

  function automatic int jit(int t);
    int r = 0;
    for (int s = 0; s <= 8; s += 4) begin
      int c = ((t >> s) & 15) + int'($urandom_range(0, 4)) - 2;
      c = (c < 0) ? 0 : (c > 15) ? 15 : c;
      r |= c << s;
    end
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pixel_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    cam = '0; hcount = '0; vcount = '0; tc0 = 12'hF00; tc1 = 12'h0F0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_pix_count", pix_count, 0);

    // Basic 4x4 red blob.
    build_test1(); run_frame(); wait_done();
    chk_t("t1_tgt0", 0, 16, 101, 51, 1);
    chk("t1_pix_count1", pix_count[CW +: CW], 0);

    // Below threshold: centroid held from previous frame.
    clr_frame();
    for (int v = 0; v < 15; v++) add_px('hF00, 10, v, 1);
    for (int v = 0; v < 5; v++) add_px('h123, 11, v, 1);
    run_frame(); wait_done();
    chk_t("t3_tgt0", 0, 15, 101, 51, 0);

    // Matching colour with pixel_valid low is ignored.
    clr_frame();
    for (int i = 0; i < 20; i++) add_px('hE00, i, 3, 0);
    for (int i = 0; i < 4; i++) add_px('hE00, 0, 0, 1);
    run_frame(); wait_done();
    chk_t("t4_tgt0", 0, 4, 101, 51, 0);

    // One pixel stream matching both targets.
    tc1 = 12'hE00;
    clr_frame();
    for (int i = 0; i < 20; i++) add_px('hE00, 5, 7, 1);
    run_frame(); wait_done();
    chk_t("t4b_tgt0", 0, 20, 5, 7, 1);
    chk_t("t4b_tgt1", 1, 20, 5, 7, 1);

    // frame_start during DIVIDE sets sticky overrun and is dropped.
    tc1 = 12'h0F0;
    build_test1(); run_frame();
    repeat (49) @(negedge clk);
    build_test1(); run_frame(); wait_done();
    chk("t5_overrun", overrun, 1);
    build_test1(); run_frame(); wait_done();
    chk_t("t5_tgt0", 0, 16, 101, 51, 1);
    chk("t5_overrun_sticky", overrun, 1);

    // Reset in the middle of DIVIDE aborts the result.
    build_test1(); run_frame();
    repeat (60) @(negedge clk);
    do_reset(1);
    chk("t6_overrun_cleared", overrun, 0);
    chk("t6_busy", busy, 0);
    chk("t6_x_center", x_center, 0);
    build_test1(); run_frame(); wait_done();
    chk_t("t6_tgt0", 0, 16, 101, 51, 1);

    // Randomized frames against the reference model.
    repeat (10) begin
      int h0, v0, sel, c;
      tc0 = 12'($urandom);
      tc1 = 12'($urandom);
      h0 = $urandom_range(0, 2030);
      v0 = $urandom_range(0, 1010);
      clr_frame();
      for (int v = 0; v < 8; v++)
        for (int h = 0; h < 8; h++) begin
          sel = $urandom_range(0, 3);
          c = (sel == 0) ? jit(int'(tc0)) : (sel == 1) ? jit(int'(tc1)) : int'($urandom_range(0, 4095));
          add_px(c, h0 + h, v0 + v, ($urandom_range(0, 9) != 0) ? 1 : 0);
        end
      run_frame(); wait_done();
    end

    repeat (3) @(negedge clk);
    chk("pending_results", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/color_blob_tracker.md
Name: color_blob_tracker

Overview:
Multi-target colour-blob tracker for the camera path. It classifies every valid camera pixel against NUM_TARGETS programmable RGB target colours. For each target it accumulates pixel count and coordinate sums over a frame. At frame end it computes integer centroids with an on-chip sequential divider and publishes per-target results with a one-cycle valid strobe for downstream steering logic.

Parameters:
NUM_TARGETS, 2, number of independent colour targets (1..4)
H_WIDTH, 11, hcount width
V_WIDTH, 10, vcount width
TOL, 1, per-component match tolerance (4-bit units)
MIN_PIXELS, 16, minimum matched pixels for found=1
CNT_W, H_WIDTH+V_WIDTH, pixel counter width (derived)
SUM_W, CNT_W+H_WIDTH, coordinate sum width (derived; H_WIDTH>=V_WIDTH)

Ports:
clk  in  1  system clock (65 MHz pixel clock)
reset  in  1  synchronous, active-high reset
pixel_valid  in  1  cam/hcount/vcount valid this cycle
cam  in  12  pixel {r[3:0],g[3:0],b[3:0]}
hcount  in  H_WIDTH  pixel column
vcount  in  V_WIDTH  pixel row
frame_start  in  1  one-cycle pulse before first pixel of frame
frame_end  in  1  one-cycle pulse after last pixel of frame
target_color  in  12*NUM_TARGETS  target k at bits [12k+11:12k]
thres_mask  out  NUM_TARGETS  registered per-target match of current pixel
x_center  out  H_WIDTH*NUM_TARGETS  per-target centroid x
y_center  out  V_WIDTH*NUM_TARGETS  per-target centroid y
pix_count  out  CNT_W*NUM_TARGETS  per-target matched pixel count of last frame
found  out  NUM_TARGETS  count >= MIN_PIXELS in last frame
result_valid  out  1  one-cycle strobe: outputs updated
busy  out  1  high in DIVIDE
overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset all outputs, accumulators and the divider are 0 and state=IDLE.
- Match rule for target k: |r-rt|<=TOL && |g-gt|<=TOL && |b-bt|<=TOL. Compare with unsigned 5-bit differences. One pixel may match several targets.
- thres_mask[k] = pixel_valid && match_k, registered with 1-cycle latency. It is evaluated in every state.
- States: IDLE, ACCUM, DIVIDE.
- IDLE: frame_start -> clear all accumulators, go to ACCUM. frame_end is ignored.
- ACCUM: on each cycle with pixel_valid && match_k: cnt_k+=1, sx_k+=hcount, sy_k+=vcount. cnt_k saturates at all-ones, and sx/sy freeze once cnt saturates.
- ACCUM: frame_start re-clears the accumulators and stays in ACCUM (restart). frame_end -> snapshot the accumulators and go to DIVIDE. frame_start and frame_end in the same cycle: frame_end wins; the frame_start is treated as arriving while busy.
- DIVIDE: restoring divider of SUM_W bits, 1 load cycle + SUM_W iteration cycles per quotient.
- DIVIDE order: sx0/cnt0, sy0/cnt0, sx1/cnt1, ... Channels with cnt_k < MIN_PIXELS skip arithmetic but still consume the same cycles, so latency is fixed.
- DIVIDE end, all channels updated together on the final cycle: found_k=(cnt_k>=MIN_PIXELS) and pix_count_k=cnt_k. If found_k=1, x/y_center_k = truncated quotient (low H_WIDTH / V_WIDTH bits). If found_k=0, x/y_center_k hold their previous values.
- DIVIDE end: result_valid pulses 1 cycle, then state returns to IDLE.
- Latency: frame_end sampled at cycle T gives result_valid high at T + NUM_TARGETS*2*(SUM_W+1) + 1. Defaults: SUM_W=32, so T+133.
- frame_start during DIVIDE: overrun is set (sticky until reset). That frame is not accumulated. The block returns to IDLE and waits for the next frame_start.
- pixel_valid=0: no accumulation regardless of cam.
- Reset mid-DIVIDE: abort; no result_valid; all outputs 0.
- Division by zero is impossible because cnt=0 implies found=0 and the divide is skipped.

Test Plan:
1. target0=F00, target1=0F0, TOL=1. Frame with cam=F00 on h=100..103, v=50..53 (16 px), others 000. Expect pix_count0=16, x_center0=101 (1624/16), y_center0=51, found=2'b01, pix_count1=0.
2. Same stimulus, result timing: frame_end at cycle T -> result_valid high exactly at T+133 for 1 cycle; busy high T+1..T+133; thres_mask[0] high 1 cycle after each red pixel.
3. Frame 1 as in test 1, then frame 2 with 15 red pixels at h=10. Expect found0=0, pix_count0=15, x_center0 still 101, y_center0 still 51.
4. cam=E00 (r within TOL) presented with pixel_valid=0 for 20 cycles and pixel_valid=1 for 4 pixels at h=0, v=0. Expect pix_count0=4, found0=0. A pixel matching both targets (target1=E00) increments both counts.
5. frame_start pulsed 50 cycles after frame_end. Expect overrun=1; the pixels of that frame are not counted. The next normal frame produces correct results, and overrun stays 1.
6. reset asserted 60 cycles into DIVIDE. Expect all outputs 0 on the next cycle, no result_valid, state IDLE. The following full frame yields test-1 values.
